// File: rtl/traffic_pkg.sv
// Shared constants and types for the intersection controller input side:
// lamp encodings, sensor channel indices and the per-channel request state.
package traffic_pkg;

  localparam int unsigned NUM_SNS = 5;

  localparam logic [4:0] LAMP_RED  = 5'b10000;
  localparam logic [4:0] LAMP_YEL  = 5'b01000;
  localparam logic [4:0] LAMP_GRN  = 5'b00100;
  localparam logic [4:0] LAMP_YARW = 5'b00010;
  localparam logic [4:0] LAMP_GARW = 5'b00001;

  localparam int unsigned SNS_LEFT_MAIN  = 0;
  localparam int unsigned SNS_LEFT_CROSS = 1;
  localparam int unsigned SNS_TRAF_CROSS = 2;
  localparam int unsigned SNS_WALK_MAIN  = 3;
  localparam int unsigned SNS_WALK_CROSS = 4;

  typedef enum logic {
    REQ_IDLE,
    REQ_PENDING
  } req_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter and a one-cycle
// strobe on each debounced rising edge.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o,
  output logic pulse_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // rise_q marks the cycle after the level flip; the visible strobe lags it by
  // one more cycle so the request latch and press_pulse update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      pulse_q <= rise_q;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o  = rise_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/traffic_sensor_front.sv
// Sensor front end: debounces raw inputs, latches presses as sticky requests
// and clears them when the lamps show service. Define REQ_AGE_EN for req_starved.
module traffic_sensor_front
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_WAIT        = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SNS-1:0] raw_sensors,
  input  logic [4:0]         main_lights,
  input  logic [4:0]         cross_lights,
  output logic [NUM_SNS-1:0] sensors,
  output logic [NUM_SNS-1:0] press_pulse,
  output logic [NUM_SNS-1:0] req_starved
);

  if (DEBOUNCE_CYCLES < 2 || MAX_WAIT < 1) begin : g_bad_params
    $error("traffic_sensor_front: DEBOUNCE_CYCLES must be >= 2 and MAX_WAIT >= 1");
  end

  logic [NUM_SNS-1:0] rise;
  logic [NUM_SNS-1:0] served;
  req_state_e         state_q [NUM_SNS];
  req_state_e         state_d [NUM_SNS];

  for (genvar g = 0; g < NUM_SNS; g++) begin : g_deb
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_sensors[g]),
      .rise_o (rise[g]),
      .pulse_o(press_pulse[g])
    );
  end

  // Exact vector compares: all-red, multi-hot or unknown lamps never serve.
  always_comb begin
    served                 = '0;
    served[SNS_LEFT_MAIN]  = (main_lights  == LAMP_GARW);
    served[SNS_LEFT_CROSS] = (cross_lights == LAMP_GARW);
    served[SNS_TRAF_CROSS] = (cross_lights == LAMP_GRN);
    served[SNS_WALK_MAIN]  = (main_lights  == LAMP_GRN);
    served[SNS_WALK_CROSS] = (cross_lights == LAMP_GRN);
  end

  always_comb begin
    sensors = '0;
    for (int unsigned i = 0; i < NUM_SNS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        REQ_IDLE:    if (rise[i] && !served[i]) state_d[i] = REQ_PENDING;
        REQ_PENDING: if (served[i])             state_d[i] = REQ_IDLE;
        default:     state_d[i] = REQ_IDLE;
      endcase
      sensors[i] = (state_q[i] == REQ_PENDING);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SNS; i++) state_q[i] <= REQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef REQ_AGE_EN
  localparam int unsigned AW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0] age_q [NUM_SNS];
  logic [AW-1:0] age_d [NUM_SNS];

  always_comb begin
    req_starved = '0;
    for (int unsigned i = 0; i < NUM_SNS; i++) begin
      if (state_q[i] == REQ_IDLE)          age_d[i] = '0;
      else if (age_q[i] == AW'(MAX_WAIT))  age_d[i] = age_q[i];
      else                                 age_d[i] = age_q[i] + 1'b1;
      req_starved[i] = (state_q[i] == REQ_PENDING) && (age_q[i] == AW'(MAX_WAIT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SNS; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign req_starved = '0;
`endif

endmodule

// File: tb/tb_traffic_sensor_front.sv
// Scoreboard bench for traffic_sensor_front (DEBOUNCE_CYCLES=4, MAX_WAIT=8).
module tb_traffic_sensor_front;

  localparam int unsigned DEB = 4;
  localparam int unsigned MW  = 8;
`ifdef REQ_AGE_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  localparam logic [4:0] RED  = 5'b10000;
  localparam logic [4:0] GRN  = 5'b00100;
  localparam logic [4:0] GARW = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] raw, ml, cl;
  logic [4:0] sensors, press_pulse, req_starved;

  traffic_sensor_front #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_WAIT       (MW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_sensors (raw),
    .main_lights (ml),
    .cross_lights(cl),
    .sensors     (sensors),
    .press_pulse (press_pulse),
    .req_starved (req_starved)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [4:0] sns;
    logic [4:0] stv;
    bit         chk_p;
    string      name;
  } exp_t;

  typedef struct {
    int         at;
    logic [4:0] v;
  } pls_t;

  exp_t exp_q[$];
  pls_t pls_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic expect_at(input int dly, input logic [4:0] s, input logic [4:0] st,
                           input bit cp, input string nm);
    exp_t e;
    e.at = cyc + dly; e.sns = s; e.stv = st; e.chk_p = cp; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_pulse(input int dly, input logic [4:0] v);
    pls_t p;
    p.at = cyc + dly; p.v = v;
    pls_q.push_back(p);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    pls_t p;
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      e = exp_q.pop_front();
      compared++;
      if (sensors !== e.sns || req_starved !== e.stv || (e.chk_p && press_pulse !== 5'b0)) begin
        mismatched++;
        $display("FAIL %s @%0d: sensors=%b starved=%b pulse=%b, want sensors=%b starved=%b%s",
                 e.name, cyc, sensors, req_starved, press_pulse, e.sns, e.stv,
                 e.chk_p ? " pulse=00000" : "");
      end
    end
    if (press_pulse !== 5'b0) begin
      compared++;
      if (pls_q.size() == 0) begin
        mismatched++;
        $display("FAIL pulse_unexpected @%0d: pulse=%b, want none", cyc, press_pulse);
      end else begin
        p = pls_q.pop_front();
        if (p.at != cyc || press_pulse !== p.v) begin
          mismatched++;
          $display("FAIL pulse @%0d: pulse=%b, want %b @%0d", cyc, press_pulse, p.v, p.at);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; raw = '0; ml = RED; cl = RED;
    tick(2);
    expect_at(0, 5'b0, 5'b0, 1'b1, "reset_state");
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // short glitch on traffic cross never debounces
    raw[2] = 1'b1; tick(3); raw[2] = 1'b0;
    expect_at(7, 5'b0, 5'b0, 1'b1, "glitch_3");
    tick(10);

    // held press: latency DEB+2 edges from first sample
    raw[2] = 1'b1;
    expect_at(6, 5'b0, 5'b0, 1'b1, "deb_lat_before");
    expect_at(7, 5'b00100, 5'b0, 1'b0, "deb_lat_set");
    expect_pulse(7, 5'b00100);
    tick(8);

    // serve while raw still held; no re-request until release and re-press
    cl = GRN;
    expect_at(1, 5'b0, 5'b0, 1'b0, "serve_cross");
    tick(3); cl = RED;
    expect_at(8, 5'b0, 5'b0, 1'b1, "held_no_rereq");
    tick(8); raw[2] = 1'b0;
    tick(10); raw[2] = 1'b1;
    expect_at(7, 5'b00100, 5'b0, 1'b0, "repress");
    expect_pulse(7, 5'b00100);
    tick(8); cl = GRN;
    tick(2); cl = RED; raw[2] = 1'b0;
    tick(10);
    expect_at(0, 5'b0, 5'b0, 1'b1, "clean_after_repress");
    tick(1);

    // press arriving while already served is dropped
    ml = GARW; raw[0] = 1'b1;
    expect_pulse(7, 5'b00001);
    expect_at(8, 5'b0, 5'b0, 1'b0, "drop_served_press");
    tick(10); ml = RED;
    expect_at(8, 5'b0, 5'b0, 1'b1, "no_rereq_after_drop");
    tick(9); raw[0] = 1'b0;
    tick(10);

    // illegal multi-hot lamps do not serve
    raw[3] = 1'b1;
    expect_pulse(7, 5'b01000);
    expect_at(7, 5'b01000, 5'b0, 1'b0, "walk_main_set");
    tick(8); ml = 5'b11111;
    expect_at(5, 5'b01000, 5'b0, 1'b1, "illegal_not_served");
    tick(5); ml = GRN;
    expect_at(1, 5'b0, 5'b0, 1'b1, "walk_main_served");
    tick(2); ml = RED; raw[3] = 1'b0;
    tick(10);

    // starvation on left cross
    raw[1] = 1'b1;
    expect_pulse(7, 5'b00010);
    expect_at(7, 5'b00010, 5'b0, 1'b0, "left_cross_set");
    expect_at(14, 5'b00010, 5'b0, 1'b1, "age_below");
    expect_at(15, 5'b00010, AGE_ON ? 5'b00010 : 5'b0, 1'b1, "starved_set");
    expect_at(16, 5'b00010, AGE_ON ? 5'b00010 : 5'b0, 1'b1, "starved_hold");
    tick(16); cl = GARW;
    expect_at(1, 5'b0, 5'b0, 1'b1, "starved_clear");
    tick(2); cl = RED; raw[1] = 1'b0;
    tick(10);

    // reset mid-run with every input held
    raw = 5'h1F;
    expect_pulse(7, 5'h1F);
    expect_at(7, 5'h1F, 5'b0, 1'b0, "all_set");
    tick(9); rst_n = 1'b0;
    expect_at(0, 5'b0, 5'b0, 1'b1, "reset_midrun");
    tick(2); rst_n = 1'b1;
    expect_at(6, 5'b0, 5'b0, 1'b1, "post_rst_before");
    expect_at(7, 5'h1F, 5'b0, 1'b0, "post_rst_set");
    expect_pulse(7, 5'h1F);
    tick(10);

    while (pls_q.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL pulse_missing: no strobe observed, want %b @%0d", pls_q[0].v, pls_q[0].at);
      void'(pls_q.pop_front());
    end
    while (exp_q.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL %s: not checked, want sensors=%b @%0d", exp_q[0].name, exp_q[0].sns, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
